// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the multiplexed BCD display driver.
package bcd_disp_pkg;

  // Scan FSM: dead-time slot with all anodes off, then the digit drive slot.
  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  // Blank overrides everything; non-decimal nibbles show a dash.
  always_comb begin
    seg_n_o = SEG_DASH;
    if (blank_i) begin
      seg_n_o = SEG_BLANK;
    end else begin
      case (nib_i)
        4'd0:    seg_n_o = SEG_0;
        4'd1:    seg_n_o = SEG_1;
        4'd2:    seg_n_o = SEG_2;
        4'd3:    seg_n_o = SEG_3;
        4'd4:    seg_n_o = SEG_4;
        4'd5:    seg_n_o = SEG_5;
        4'd6:    seg_n_o = SEG_6;
        4'd7:    seg_n_o = SEG_7;
        4'd8:    seg_n_o = SEG_8;
        4'd9:    seg_n_o = SEG_9;
        default: seg_n_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed seven-segment scanner: stages packed BCD via valid/ready, swaps
// it in at frame boundaries, and drives one digit at a time with dead-time.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW      = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]         stage_q, stage_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic                  in_ready_q, in_ready_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;
  logic                  boundary_s, accept_s;
  logic [NUM_DIGITS-1:0] lz_mask_s;
  logic [3:0]            nib_s;
  logic                  blank_s;
  logic [6:0]            seg_dec_s;

  assign boundary_s = (state_q == ST_DRIVE) && (idx_q == IDX_LAST) && (cnt_q == DRIVE_LAST);
  assign accept_s   = in_valid && in_ready_q;

  // Scan FSM next state: GUARD then DRIVE per digit, index wraps after the last.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          state_d = ST_GUARD;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_GUARD;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Staging handshake: a boundary-cycle accept can never coincide with a swap
  // because the swap needs pending set, which holds ready low.
  always_comb begin
    stage_d   = stage_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (boundary_s && pending_q) begin
      disp_d    = stage_q;
      pending_d = 1'b0;
    end else if (accept_s) begin
      stage_d   = bcd_in;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    in_ready_d = !pending_d;
  end

  // Leading-zero mask: a digit blanks when it and all higher digits are zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_mask_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_q[4*i +: 4] == 4'd0);
      lz_mask_s[i] = blank_lz && zero_run && (i != 0);
    end
  end

  // The decoder looks at the digit that will own the bus next cycle.
  assign nib_s   = disp_q[4*idx_d +: 4];
  assign blank_s = lz_mask_s[idx_d];

  bcd_to_seg u_dec (
    .nib_i   (nib_s),
    .blank_i (blank_s),
    .seg_n_o (seg_dec_s)
  );

  // Output next values describe the upcoming slot so the registers match it.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    fd_d  = 1'b0;
    if (state_d == ST_DRIVE) begin
      seg_d        = seg_dec_s;
      an_d[idx_d]  = 1'b0;
      fd_d         = (idx_d == IDX_LAST) && (cnt_d == DRIVE_LAST);
    end else begin
      seg_d = SEG_BLANK;
    end
  end

  // State, staging and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_GUARD;
      idx_q      <= '0;
      cnt_q      <= '0;
      stage_q    <= '0;
      disp_q     <= '0;
      pending_q  <= 1'b0;
      in_ready_q <= 1'b1;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      disp_q     <= disp_d;
      pending_q  <= pending_d;
      in_ready_q <= in_ready_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: frame-position reference model plus
// directed literal checks and randomized traffic.
module tb_bcd_seg_scan;

  localparam int ND   = 2;
  localparam int RD   = 4;
  localparam int GC   = 1;
  localparam int SLOT = GC + RD;
  localparam int FR   = ND * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bcd_in;
  logic       in_valid;
  logic       in_ready;
  logic       blank_lz;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_seg_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  // Reference model: cycle number since reset, shown/staged values.
  int         m_t;
  logic [7:0] m_disp;
  logic [7:0] m_stage;
  bit         m_pend;
  bit         m_blank;

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic void model_out(output logic [6:0] s, output logic [1:0] a, output logic f);
    int pos, slot, off;
    logic [7:0] upper;
    pos  = m_t % FR;
    slot = pos / SLOT;
    off  = pos % SLOT;
    f    = (pos == FR - 1);
    a    = 2'b11;
    s    = 7'h7F;
    if (off >= GC) begin
      a[slot] = 1'b0;
      upper   = m_disp >> (4 * slot);
      if (m_blank && slot != 0 && upper == 8'h00) s = 7'h7F;
      else s = seg_of(upper[3:0]);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= 0;
      m_disp  <= 8'h00;
      m_stage <= 8'h00;
      m_pend  <= 1'b0;
      m_blank <= 1'b0;
    end else begin
      if ((m_t % FR == FR - 1) && m_pend) begin
        m_disp <= m_stage;
        m_pend <= 1'b0;
      end else if (in_valid && !m_pend) begin
        m_stage <= bcd_in;
        m_pend  <= 1'b1;
      end
      m_blank <= blank_lz;
      m_t     <= m_t + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [6:0] es;
    logic [1:0] ea;
    logic       ef;
    if (chk_en) begin
      model_out(es, ea, ef);
      check("seg_n", {1'b0, seg_n}, {1'b0, es});
      check("an_n", {6'b0, an_n}, {6'b0, ea});
      check("frame_done", {7'b0, frame_done}, {7'b0, ef});
      check("in_ready", {7'b0, in_ready}, {7'b0, !m_pend});
      check("an_overlap", {7'b0, (an_n == 2'b00)}, 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(string nm, logic [6:0] es, logic [1:0] ea);
    check({nm, "_seg"}, {1'b0, seg_n}, {1'b0, es});
    check({nm, "_an"}, {6'b0, an_n}, {6'b0, ea});
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 4 * FR) begin
      tick();
      k++;
    end
    check("frame_done_seen", {7'b0, frame_done}, 8'h01);
  endtask

  task automatic load(logic [7:0] v);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 4 * FR) begin
      tick();
      k++;
    end
    bcd_in   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Checks the next full frame: digit 0 first drive cycle, digit 1 first drive cycle.
  task automatic check_frame(string nm, logic [6:0] d0, logic [6:0] d1);
    wait_fd();
    tick();
    tick();
    lit({nm, "_d0"}, d0, 2'b10);
    repeat (5) tick();
    lit({nm, "_d1"}, d1, 2'b01);
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    bcd_in   = 8'h00;
    in_valid = 1'b0;
    blank_lz = 1'b0;
    #1 chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    // cycle 0 after release: guard of digit 0
    lit("rst_guard", 7'h7F, 2'b11);
    tick();
    lit("rst_d0", 7'h40, 2'b10);
    check("rst_ready", {7'b0, in_ready}, 8'h01);

    // load 42
    bcd_in   = 8'h42;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ready_drop", {7'b0, in_ready}, 8'h00);
    check_frame("v42", 7'h24, 7'h19);
    check("ready_back", {7'b0, in_ready}, 8'h01);

    // leading-zero blanking and invalid nibbles
    blank_lz = 1'b1;
    load(8'h07);
    check_frame("v07_lz", 7'h78, 7'h7F);
    blank_lz = 1'b0;
    check_frame("v07_nolz", 7'h78, 7'h40);
    blank_lz = 1'b1;
    load(8'h00);
    check_frame("v00_lz", 7'h40, 7'h7F);
    blank_lz = 1'b0;
    load(8'hA9);
    check_frame("vA9", 7'h10, 7'h3F);
    blank_lz = 1'b1;
    load(8'h0F);
    check_frame("v0F_lz", 7'h3F, 7'h7F);
    blank_lz = 1'b0;

    // back-pressure: 99 held until ready rises
    load(8'h11);
    bcd_in   = 8'h99;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 4 * FR) begin
      tick();
      k++;
    end
    check("bp_ready", {7'b0, in_ready}, 8'h01);
    tick();
    in_valid = 1'b0;
    lit("bp_v11", 7'h79, 2'b10);
    check("bp_taken", {7'b0, in_ready}, 8'h00);
    check_frame("bp_v99", 7'h10, 7'h10);

    // accept on the boundary cycle itself
    wait_fd();
    bcd_in   = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    lit("bnd_old", 7'h10, 2'b10);
    check_frame("bnd_v55", 7'h12, 7'h12);

    // reset mid-drive with data pending
    wait_fd();
    tick();
    tick();
    load(8'h33);
    #1 rst_n = 1'b0;
    #1;
    lit("rst_mid", 7'h7F, 2'b11);
    check("rst_mid_ready", {7'b0, in_ready}, 8'h01);
    check("rst_mid_fd", {7'b0, frame_done}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    lit("rst2_guard", 7'h7F, 2'b11);
    tick();
    lit("rst2_d0", 7'h40, 2'b10);
    check_frame("rst2_clear", 7'h40, 7'h40);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      bcd_in   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bcd_in[7:4] = 4'h0;
      if ($urandom_range(0, 5) == 0) bcd_in[3:0] = 4'h0;
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      tick();
    end
    in_valid = 1'b0;
    repeat (3 * FR) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
